// File: rtl/uart_tx.sv
// UART transmitter: serialises one start/data/parity/stop frame per request, paced by an
// oversampling tick from the baud generator and gated by a synchronised clear-to-send.
module uart_tx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_tick,
  input  logic [1:0]  data_bit_num_i,
  input  logic        start_tx_i,
  input  logic        parity_en_i,
  input  logic        parity_type_i,
  input  logic        stop_bit_num_i,
  input  logic [31:0] tx_data_i,
  output logic        tx_busy_o,
  output logic        tx_done_o,
  output logic        tx,
  input  logic        cts_n
);

  localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} state_e;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             pending_q, pending_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             cts_meta_q, cts_sync_q;

  logic       accept;
  logic       bit_end;
  logic [2:0] bit_last;
  logic [7:0] data_mask;
  logic       req_parity;
  logic       unused_data_hi;

  assign unused_data_hi = ^tx_data_i[31:8];

  assign accept     = start_tx_i && (state_q == TxIdle) && !pending_q;
  assign bit_last   = {1'b0, nbits_q} + 3'd4;
  // Parity is taken from the request word, since the shift register loses bits as it runs.
  assign data_mask  = 8'hff >> (2'd3 - data_bit_num_i);
  assign req_parity = (^(tx_data_i[7:0] & data_mask)) ^ parity_type_i;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    pending_d  = pending_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    done_d     = 1'b0;
    bit_end    = 1'b0;

    if (state_q != TxIdle && tx_tick) begin
      if (tick_cnt_q == TickLast) begin
        tick_cnt_d = '0;
        bit_end    = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    if (accept) begin
      pending_d = 1'b1;
      shift_d   = tx_data_i[7:0];
      nbits_d   = data_bit_num_i;
      par_en_d  = parity_en_i;
      par_bit_d = req_parity;
      stop2_d   = stop_bit_num_i;
    end

    unique case (state_q)
      TxIdle: begin
        if (pending_q && !cts_sync_q) begin
          state_d    = TxStart;
          pending_d  = 1'b0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      TxStart: begin
        if (bit_end) state_d = TxData;
      end
      TxData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == bit_last) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? TxParity : TxStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      TxParity: begin
        if (bit_end) state_d = TxStop;
      end
      TxStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = TxIdle;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // Line level follows the current state, so tx lags each transition by one clk.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      TxStart:  tx_d = 1'b0;
      TxData:   tx_d = shift_q[0];
      TxParity: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TxIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      pending_q  <= 1'b0;
      shift_q    <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      pending_q  <= pending_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign tx        = tx_q;
  assign tx_done_o = done_q;
  assign tx_busy_o = pending_q | (state_q != TxIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: decodes the serial line against a frame model built from data/config,
// covering directed frame formats, flow control, back-to-back frames, reset and random frames.
module tb_uart_tx;

  localparam int unsigned Oversample = 16;
  localparam int TickClk = 4;
  localparam int BitClk  = Oversample * TickClk;

  logic        clk;
  logic        rst_n;
  logic        tx_tick;
  logic [1:0]  data_bit_num_i;
  logic        start_tx_i;
  logic        parity_en_i;
  logic        parity_type_i;
  logic        stop_bit_num_i;
  logic [31:0] tx_data_i;
  logic        tx_busy_o;
  logic        tx_done_o;
  logic        tx;
  logic        cts_n;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int tick_ph = 0;
  int last_fall = 0;
  int last_done = 0;

  logic [7:0] nxt_d;
  logic [1:0] nxt_nb;
  logic       nxt_pe, nxt_pt, nxt_sb;

  uart_tx #(.OVERSAMPLE(Oversample)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_tick        (tx_tick),
    .data_bit_num_i (data_bit_num_i),
    .start_tx_i     (start_tx_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .stop_bit_num_i (stop_bit_num_i),
    .tx_data_i      (tx_data_i),
    .tx_busy_o      (tx_busy_o),
    .tx_done_o      (tx_done_o),
    .tx             (tx),
    .cts_n          (cts_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tx_tick = 1'b0;
    forever begin
      @(negedge clk);
      tx_tick = (tick_ph == TickClk - 1);
      tick_ph = (tick_ph + 1) % TickClk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    tx_data_i      = $urandom();
    data_bit_num_i = 2'($urandom());
    parity_en_i    = 1'($urandom());
    parity_type_i  = 1'($urandom());
    stop_bit_num_i = 1'($urandom());
  endtask

  task automatic drive_req(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                           input logic pt, input logic sb);
    tx_data_i      = {24'($urandom()), d};
    data_bit_num_i = nb;
    parity_en_i    = pe;
    parity_type_i  = pt;
    stop_bit_num_i = sb;
    start_tx_i     = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                      input logic pt, input logic sb);
    drive_req(d, nb, pe, pt, sb);
    @(negedge clk);
    start_tx_i = 1'b0;
    scramble();
  endtask

  // Expected frame: start 0, N data bits LSB first, optional parity, 1 or 2 stop bits.
  task automatic rx_frame(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                          input logic pt, input logic sb, input int max_wait, input bit chain);
    logic exp_bits[$];
    int n, ones, t0, nbits, flen;
    bit seen;
    n = 5 + int'(nb);
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_bits.push_back(logic'(ones % 2) ^ pt);
    exp_bits.push_back(1'b1);
    if (sb) exp_bits.push_back(1'b1);
    nbits = exp_bits.size();

    seen = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("start_seen", 32'(seen), 32'd1);
    if (!seen) return;
    t0 = cyc;
    last_fall = t0;

    for (int k = 0; k < nbits; k++) begin
      while (cyc < t0 + k * BitClk + BitClk / 2 - 2) @(negedge clk);
      check_eq($sformatf("bit%0d", k), 32'(tx), 32'(exp_bits[k]));
    end

    seen = 1'b0;
    for (int i = 0; i < 2 * BitClk; i++) begin
      if (tx_done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    if (!seen) return;
    last_done = cyc;
    // Start bit may be short by up to one tick period; every later bit is exact.
    flen = cyc - t0;
    check_eq("frame_len", 32'(flen >= nbits * BitClk - TickClk && flen <= nbits * BitClk - 1),
             32'd1);
    if (chain) begin
      drive_req(nxt_d, nxt_nb, nxt_pe, nxt_pt, nxt_sb);
      @(negedge clk);
      start_tx_i = 1'b0;
      scramble();
      check_eq("done_pulse", 32'(tx_done_o), 32'd0);
    end else begin
      @(negedge clk);
      check_eq("done_pulse", 32'(tx_done_o), 32'd0);
      check_eq("busy_after", 32'(tx_busy_o), 32'd0);
    end
  endtask

  initial begin
    int lat, d1, bad_cnt, t0;
    logic [7:0] rd;
    logic [1:0] rnb;
    logic rpe, rpt, rsb;
    bit seen;

    rst_n = 1'b0;
    start_tx_i = 1'b0;
    cts_n = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(tx_busy_o), 32'd0);
    check_eq("rst_done", 32'(tx_done_o), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5, then 7E2 / 7O2 0x41, then 5N1 0xFF
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    rx_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 100, 1'b0);
    send(8'h41, 2'b10, 1'b1, 1'b0, 1'b1);
    rx_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 100, 1'b0);
    send(8'h41, 2'b10, 1'b1, 1'b1, 1'b1);
    rx_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b1, 100, 1'b0);
    send(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0);
    rx_frame(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 100, 1'b0);

    // Request held off by cts_n; a second request during the wait is dropped
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("cts_hold_tx", 32'(tx), 32'd1);
    check_eq("cts_hold_busy", 32'(tx_busy_o), 32'd1);
    send(8'hC3, 2'b11, 1'b1, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    cts_n = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("cts_latency", 32'(seen && lat >= 3 && lat <= 4), 32'd1);
    rx_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 10, 1'b0);

    // cts_n raised mid-frame; back-to-back request on the done cycle
    nxt_d = 8'h2B; nxt_nb = 2'b11; nxt_pe = 1'b0; nxt_pt = 1'b0; nxt_sb = 1'b0;
    send(8'h96, 2'b11, 1'b1, 1'b0, 1'b0);
    fork
      rx_frame(8'h96, 2'b11, 1'b1, 1'b0, 1'b0, 100, 1'b1);
      begin
        repeat (4 * BitClk + 20) @(negedge clk);
        cts_n = 1'b1;
        repeat (3 * BitClk) @(negedge clk);
        cts_n = 1'b0;
      end
    join
    d1 = last_done;
    rx_frame(8'h2B, 2'b11, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    check_eq("b2b_gap", 32'(last_fall - d1 >= 1 && last_fall - d1 <= 4), 32'd1);

    // Random frames; config and data inputs are scrambled while each frame runs
    for (int r = 0; r < 8; r++) begin
      rd  = 8'($urandom());
      rnb = 2'($urandom());
      rpe = 1'($urandom());
      rpt = 1'($urandom());
      rsb = 1'($urandom());
      send(rd, rnb, rpe, rpt, rsb);
      rx_frame(rd, rnb, rpe, rpt, rsb, 100, 1'b0);
    end

    // Reset during the parity bit of 7E1 0x41 (parity 0)
    send(8'h41, 2'b10, 1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("rst_frame_start", 32'(seen), 32'd1);
    t0 = cyc;
    while (cyc < t0 + 8 * BitClk + BitClk / 2 - 2) @(negedge clk);
    check_eq("par_pre_rst", 32'(tx), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", 32'(tx), 32'd1);
    check_eq("async_rst_busy", 32'(tx_busy_o), 32'd0);
    check_eq("async_rst_done", 32'(tx_done_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad_cnt = 0;
    for (int i = 0; i < 4 * BitClk; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done_o !== 1'b0 || tx_busy_o !== 1'b0) bad_cnt++;
    end
    check_eq("idle_after_rst", 32'(bad_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
